// File: rtl/plu_ctrl_pkg.sv
// rtl/plu_ctrl_pkg.sv - shared types and constants for the PLU sequencing controller
package plu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        ADD  = 3'd3,
        ACT  = 3'd4,
        FIN  = 3'd5
    } plu_state_t;

    localparam int PLU_STAGES = 4;
    localparam int ITER_W_DEF = 4;

endpackage

// File: rtl/plu_controller.sv
// rtl/plu_controller.sv - multi-pass stage sequencer for one 4-input PLU datapath
// Optional: PLU_CTRL_ABORT_EN adds an abort input that returns the FSM to IDLE.
module plu_controller
    import plu_ctrl_pkg::*;
#(
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
`ifdef PLU_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              w_we,
    output logic              a_we,
    output logic              a_sel,
    output logic              r1_we,
    output logic              r2_we,
    output logic              r3_we,
    output logic [ITER_W-1:0] iter_cnt
);

    plu_state_t        state, state_nx;
    logic [ITER_W-1:0] iter_nx;
    logic [ITER_W-1:0] n_lat, n_nx;
    logic              abort_i;

`ifdef PLU_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter_cnt <= '0;
            n_lat    <= '0;
        end else begin
            state    <= state_nx;
            iter_cnt <= iter_nx;
            n_lat    <= n_nx;
        end
    end

    always_comb begin
        state_nx = state;
        iter_nx  = iter_cnt;
        n_nx     = n_lat;
        if (state == IDLE) begin
            // abort takes priority over a simultaneous start
            if (start && !abort_i) begin
                state_nx = LOAD;
                iter_nx  = '0;
                n_nx     = (num_iter == '0) ? ITER_W'(1) : num_iter;
            end
        end else if (abort_i) begin
            state_nx = IDLE;
            iter_nx  = '0;
        end else begin
            case (state)
                LOAD:    state_nx = MUL;
                MUL:     state_nx = ADD;
                ADD:     state_nx = ACT;
                ACT: begin
                    if (iter_cnt == n_lat - ITER_W'(1)) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = LOAD;
                        iter_nx  = iter_cnt + ITER_W'(1);
                    end
                end
                FIN:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Moore decode: outputs depend only on registered state and iter_cnt
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        w_we  = 1'b0;
        a_we  = 1'b0;
        a_sel = 1'b0;
        r1_we = 1'b0;
        r2_we = 1'b0;
        r3_we = 1'b0;
        case (state)
            LOAD: begin
                busy  = 1'b1;
                a_we  = 1'b1;
                w_we  = (iter_cnt == '0);
                a_sel = (iter_cnt != '0);
            end
            MUL: begin
                busy  = 1'b1;
                r1_we = 1'b1;
            end
            ADD: begin
                busy  = 1'b1;
                r2_we = 1'b1;
            end
            ACT: begin
                busy  = 1'b1;
                r3_we = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

endmodule
